// File: rtl/i2c_master_byte.sv
// Bit-level I2C master: one feed runs START, address byte, one data byte (write or read), STOP.
// SCL advances in quarter-periods of CLK_DIV clocks; the quarter timer holds while a slave stretches SCL.
module i2c_master_byte #(
  parameter int CLK_DIV = 250
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       feed,
  input  logic [7:0] addr,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       tx_ack,
  output logic       busy,
  output logic       idle,
  output logic       done,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic [2:0] {IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [2:0]      bit_q, bit_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      addr_q, addr_d, tx_q, tx_d, shift_q, shift_d, rx_data_q, rx_data_d;
  logic            rx_ack_q, rx_ack_d, tx_ack_q, tx_ack_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic            stretch, tick, bit_val;

  always_comb begin
    stretch   = ~scl_oe_q & ~scl_i;
    tick      = busy_q & ~stretch & (cnt_q == CW'(CLK_DIV - 1));
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    rx_ack_d  = rx_ack_q;
    tx_ack_d  = tx_ack_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_d     = cnt_q;
    if (!busy_q)
      cnt_d = '0;
    else if (!stretch)
      cnt_d = tick ? '0 : cnt_q + CW'(1);

    if (feed && !busy_q) begin
      addr_d    = addr;
      tx_d      = tx_data;
      shift_d   = 8'd0;
      rx_data_d = 8'd0;
      rx_ack_d  = 1'b0;
      tx_ack_d  = 1'b0;
      busy_d    = 1'b1;
      state_d   = START;
      qtr_d     = 2'd0;
      bit_d     = 3'd7;
      cnt_d     = '0;
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        START: if (qtr_q == 2'd1) begin
          state_d = ADDR;
          qtr_d   = 2'd0;
          bit_d   = 3'd7;
        end
        ADDR, DATA: begin
          if (qtr_q == 2'd2 && state_q == DATA && addr_q[0])
            shift_d = {shift_q[6:0], sda_i};
          if (qtr_q == 2'd3) begin
            bit_d = bit_q - 3'd1;
            if (bit_q == 3'd0) begin
              state_d = (state_q == ADDR) ? ADDR_ACK : DATA_ACK;
              // Read byte becomes visible only once all eight bits are in.
              if (state_q == DATA && addr_q[0])
                rx_data_d = shift_q;
            end
          end
        end
        ADDR_ACK: begin
          if (qtr_q == 2'd2)
            rx_ack_d = ~sda_i;
          if (qtr_q == 2'd3) begin
            state_d = rx_ack_q ? DATA : STOP;
            bit_d   = 3'd7;
          end
        end
        DATA_ACK: begin
          if (qtr_q == 2'd2 && !addr_q[0])
            tx_ack_d = ~sda_i;
          if (qtr_q == 2'd3)
            state_d = STOP;
        end
        STOP: if (qtr_q == 2'd2) begin
          state_d = IDLE;
          qtr_d   = 2'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: ;
      endcase
    end

    // Pad drive is derived from the quarter being entered so it is registered with the state.
    bit_val = 1'b1;
    if (state_d == ADDR)
      bit_val = addr_d[bit_d];
    else if (state_d == DATA && !addr_d[0])
      bit_val = tx_d[bit_d];
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    case (state_d)
      START: begin
        sda_oe_d = 1'b1;
        scl_oe_d = (qtr_d == 2'd1);
      end
      ADDR, ADDR_ACK, DATA, DATA_ACK: begin
        scl_oe_d = ~qtr_d[1];
        sda_oe_d = ~bit_val;
      end
      STOP: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d != 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      cnt_q     <= '0;
      addr_q    <= 8'd0;
      tx_q      <= 8'd0;
      shift_q   <= 8'd0;
      rx_data_q <= 8'd0;
      rx_ack_q  <= 1'b0;
      tx_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      rx_ack_q  <= rx_ack_d;
      tx_ack_q  <= tx_ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rx_ack  = rx_ack_q;
  assign tx_ack  = tx_ack_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;
  assign idle    = ~busy_q & scl_i & sda_i;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: open-drain bus with a behavioural I2C slave, checked against a
// transaction-level model of expected bus bits, busy length and returned status.
module tb_i2c_master_byte;
  localparam int D = 4;

  logic       aclk = 1'b0;
  logic       aresetn = 1'b0;
  logic       feed = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] tx_data = 8'd0;
  logic [7:0] rx_data;
  logic       rx_ack, tx_ack, busy, idle, done, scl_oe, sda_oe;
  logic       s_sda_low = 1'b0;
  logic       s_scl_low = 1'b0;
  logic       scl_line, sda_line;

  assign scl_line = ~scl_oe & ~s_scl_low;
  assign sda_line = ~sda_oe & ~s_sda_low;

  i2c_master_byte #(.CLK_DIV(D)) dut (
    .aclk(aclk), .aresetn(aresetn), .feed(feed), .addr(addr), .tx_data(tx_data),
    .rx_data(rx_data), .rx_ack(rx_ack), .tx_ack(tx_ack), .busy(busy), .idle(idle),
    .done(done), .scl_i(scl_line), .sda_i(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          sl_present = 1'b0, sl_dack = 1'b0, sl_stretch = 1'b0, slave_rst = 1'b1;
  logic [7:0]  sl_rdata = 8'd0;
  logic [31:0] last_bits = 32'd0;
  int          last_n = 0;
  int          stop_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave: detects START/STOP, records SDA at each SCL rise, drives ACK/read bits while SCL is low.
  initial begin : slave
    logic ps, pd, cs, cd, rw, act;
    logic [31:0] obs;
    int bitn, scnt;
    ps = 1'b1; pd = 1'b1; rw = 1'b0; act = 1'b0; obs = 32'd0; bitn = 0; scnt = 0;
    forever begin
      @(negedge aclk);
      if (slave_rst) begin
        act = 1'b0; s_sda_low = 1'b0; s_scl_low = 1'b0; bitn = 0; obs = 32'd0;
        ps = 1'b1; pd = 1'b1;
      end else begin
        cs = scl_line;
        cd = sda_line;
        if (ps && cs && pd && !cd) begin
          act = 1'b1; bitn = 0; obs = 32'd0;
        end else if (act && ps && cs && !pd && cd) begin
          act = 1'b0;
          last_bits = obs >> 1;
          last_n = bitn - 1;
          stop_cnt++;
        end else if (act && !ps && cs) begin
          obs = {obs[30:0], cd};
          bitn++;
        end else if (act && ps && !cs) begin
          if (bitn == 8) rw = obs[0];
          s_sda_low = 1'b0;
          if (bitn == 8)
            s_sda_low = sl_present;
          else if (bitn >= 9 && bitn <= 16)
            s_sda_low = sl_present && rw && !sl_rdata[16-bitn];
          else if (bitn == 17)
            s_sda_low = sl_present && !rw && sl_dack;
          if (sl_stretch && bitn == 4) begin
            s_scl_low = 1'b1;
            scnt = 0;
          end
        end
        if (s_scl_low && !scl_oe) begin
          if (scnt == 40) s_scl_low = 1'b0;
          else scnt++;
        end
        ps = cs;
        pd = cd;
      end
    end
  end

  task automatic wait_done(input int refeed_at, input bit chain, input logic [7:0] a2,
                           input logic [7:0] d2, output int bcyc, output bit ok);
    bcyc = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      feed = 1'b0;
      if (busy) bcyc++;
      if (busy && bcyc == refeed_at) begin
        feed = 1'b1;
        addr = ~addr;
        tx_data = ~tx_data;
      end
      if (done) begin
        ok = 1'b1;
        if (chain) begin
          feed = 1'b1;
          addr = a2;
          tx_data = d2;
        end
        break;
      end
    end
    chk("done_seen", ok, 1'b1);
  endtask

  // Reference: bus bits are address, slave ACK, then (if ACKed) data byte and its ACK bit.
  task automatic check_txn(input logic [7:0] a, input logic [7:0] d, input bit pres, input bit dack,
                           input bit stretch, input logic [7:0] rd, input int bcyc, input int s0);
    logic [31:0] eb;
    int en, q;
    bit rw;
    rw = a[0];
    if (pres) begin
      eb = {14'd0, a, 1'b0, (rw ? rd : d), (rw ? 1'b1 : ~dack)};
      en = 18;
      q = 2 + 36 + 36 + 3;
    end else begin
      eb = {23'd0, a, 1'b1};
      en = 9;
      q = 2 + 36 + 3;
    end
    chk("busy_cycles", bcyc, q * D + (stretch ? 40 : 0));
    chk("bus_bit_count", last_n, en);
    chk("bus_bits", last_bits, eb);
    chk("stop_seen", stop_cnt - s0, 1);
    chk("rx_ack", rx_ack, pres);
    chk("tx_ack", tx_ack, pres & ~rw & dack);
    chk("rx_data", rx_data, (pres & rw) ? rd : 8'd0);
  endtask

  task automatic run_txn(input logic [7:0] a, input logic [7:0] d, input bit pres, input bit dack,
                         input bit stretch, input logic [7:0] rd, input int refeed_at);
    int bcyc, s0;
    bit ok;
    sl_present = pres; sl_dack = dack; sl_stretch = stretch; sl_rdata = rd;
    s0 = stop_cnt;
    @(negedge aclk);
    addr = a; tx_data = d; feed = 1'b1;
    wait_done(refeed_at, 1'b0, 8'd0, 8'd0, bcyc, ok);
    check_txn(a, d, pres, dack, stretch, rd, bcyc, s0);
    @(negedge aclk);
    chk("done_single_pulse", done, 1'b0);
    chk("idle_after", idle, 1'b1);
    chk("scl_released", scl_oe, 1'b0);
    chk("sda_released", sda_oe, 1'b0);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int bcyc, s0;
    bit ok;
    logic [7:0] ra, rd_, rr;
    repeat (3) @(negedge aclk);
    chk("rst_scl_oe", scl_oe, 1'b0);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_rx_data", rx_data, 8'd0);
    chk("rst_rx_ack", rx_ack, 1'b0);
    chk("rst_tx_ack", tx_ack, 1'b0);
    aresetn = 1'b1;
    @(negedge aclk);
    slave_rst = 1'b0;
    @(negedge aclk);
    chk("rst_idle", idle, 1'b1);

    run_txn(8'hF0, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00, -1);
    run_txn(8'hF1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h5C, -1);
    run_txn(8'hF0, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h00, -1);
    run_txn(8'hF0, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h00, -1);
    run_txn(8'hF1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h5C, -1);
    run_txn(8'hA4, 8'h3C, 1'b1, 1'b1, 1'b0, 8'h00, 50);

    // Second feed presented on the done cycle.
    sl_present = 1'b1; sl_dack = 1'b1; sl_stretch = 1'b0; sl_rdata = 8'h96;
    s0 = stop_cnt;
    @(negedge aclk);
    addr = 8'hF0; tx_data = 8'h55; feed = 1'b1;
    wait_done(-1, 1'b1, 8'hA5, 8'h00, bcyc, ok);
    check_txn(8'hF0, 8'h55, 1'b1, 1'b1, 1'b0, 8'h96, bcyc, s0);
    s0 = stop_cnt;
    wait_done(-1, 1'b0, 8'd0, 8'd0, bcyc, ok);
    check_txn(8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 8'h96, bcyc, s0);

    // Asynchronous reset mid-transaction.
    sl_rdata = 8'h00;
    @(negedge aclk);
    addr = 8'hF1; tx_data = 8'h00; feed = 1'b1;
    bcyc = 0;
    for (int i = 0; i < 2000 && bcyc < 100; i++) begin
      @(negedge aclk);
      feed = 1'b0;
      if (busy) bcyc++;
    end
    chk("pre_rst_busy", busy, 1'b1);
    slave_rst = 1'b1;
    aresetn = 1'b0;
    #1;
    chk("async_rst_scl_oe", scl_oe, 1'b0);
    chk("async_rst_sda_oe", sda_oe, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    slave_rst = 1'b0;
    @(negedge aclk);
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_rx_ack", rx_ack, 1'b0);
    chk("post_rst_rx_data", rx_data, 8'd0);
    run_txn(8'h5A, 8'hC3, 1'b1, 1'b1, 1'b0, 8'h00, -1);

    for (int k = 0; k < 8; k++) begin
      ra  = 8'($urandom_range(0, 255));
      rd_ = 8'($urandom_range(0, 255));
      rr  = 8'($urandom_range(0, 255));
      run_txn(ra, rd_, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), rr, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
